// File: rtl/color_map_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// color_map_pkg : shared types and palette functions for color_map_pipe
// Rev 1.0
// ==========================================================================
package color_map_pkg;

  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    PAL_JET  = 2'd0,
    PAL_GRAY = 2'd1,
    PAL_HOT  = 2'd2,
    PAL_LUT  = 2'd3
  } palette_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Four linear ramps of 64 steps; every product stays inside 8 bits.
  function automatic rgb_t jet(input logic [IDX_W-1:0] i);
    rgb_t c;
    c = '0;
    if (i < 8'd64) begin
      c.r = 8'd0;
      c.g = i << 2;
      c.b = 8'd255;
    end else if (i < 8'd128) begin
      c.r = 8'd0;
      c.g = 8'd255;
      c.b = 8'd255 - ((i - 8'd64) << 2);
    end else if (i < 8'd192) begin
      c.r = (i - 8'd128) << 2;
      c.g = 8'd255;
      c.b = 8'd0;
    end else begin
      c.r = 8'd255;
      c.g = 8'd255 - ((i - 8'd192) << 2);
      c.b = 8'd0;
    end
    return c;
  endfunction

  function automatic rgb_t hot(input logic [IDX_W-1:0] i);
    rgb_t c;
    logic [7:0] dg;
    logic [7:0] db;
    dg  = i - 8'd85;
    db  = i - 8'd170;
    c.r = (i < 8'd85) ? ((i << 1) + i) : 8'd255;
    c.g = (i < 8'd85) ? 8'd0 : (i < 8'd170) ? ((dg << 1) + dg) : 8'd255;
    c.b = (i < 8'd170) ? 8'd0 : ((db << 1) + db);
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/color_lut_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// color_lut_ram : 1W/1R palette RAM, registered read-first output (BRAM)
// Rev 1.0
// ==========================================================================
module color_lut_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Read samples the array before this edge's write lands: old data wins.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= r_mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/color_map_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// color_map_pipe : contrast window + palette mapping, 3-stage valid/ready
// Rev 1.0
// ==========================================================================
module color_map_pipe
  import color_map_pkg::*;
#(
  parameter int IN_W      = 12,
  parameter int GAIN_FRAC = 8,
  parameter int LUT_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_sof,
  input  logic            in_eol,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      cfg_mode,
  input  logic [IN_W-1:0] cfg_lo,
  input  logic [15:0]     cfg_gain,
  input  logic            lut_we,
  input  logic [7:0]      lut_addr,
  input  logic [23:0]     lut_wdata,
  output logic [23:0]     rgb,
  output logic            out_sof,
  output logic            out_eol,
  output logic            out_valid,
  input  logic            out_ready
);

  logic               w_advance;
  logic [IN_W-1:0]    w_off;
  logic [IN_W+15:0]   w_prod;
  logic [IN_W+15:0]   w_scaled;
  logic [IDX_W-1:0]   w_idx;
  rgb_t               w_pal;
  rgb_t               w_s2_rgb;
  logic [23:0]        w_lut_rdata;

  logic               r_s1_valid;
  logic [IDX_W-1:0]   r_s1_idx;
  palette_e           r_s1_mode;
  logic               r_s1_sof;
  logic               r_s1_eol;

  logic               r_s2_valid;
  rgb_t               r_s2_rgb;
  palette_e           r_s2_mode;
  logic               r_s2_sof;
  logic               r_s2_eol;

  rgb_t               r_rgb;

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;
  assign rgb       = r_rgb;

  // Window: clamp below the floor, scale, then saturate to the 8-bit index.
  always_comb begin
    w_off    = (in_data >= cfg_lo) ? (in_data - cfg_lo) : '0;
    w_prod   = {16'd0, w_off} * {{IN_W{1'b0}}, cfg_gain};
    w_scaled = w_prod >> GAIN_FRAC;
    w_idx    = (|w_scaled[IN_W+15:IDX_W]) ? '1 : w_scaled[IDX_W-1:0];
  end

  always_comb begin
    w_pal = '0;
    case (r_s1_mode)
      PAL_JET:  w_pal = jet(r_s1_idx);
      PAL_GRAY: w_pal = '{r: r_s1_idx, g: r_s1_idx, b: r_s1_idx};
      PAL_HOT:  w_pal = hot(r_s1_idx);
      default:  w_pal = '0;
    endcase
  end

  // The LUT output register doubles as the S2 colour for LUT mode.
  assign w_s2_rgb = (r_s2_mode == PAL_LUT) ? rgb_t'(w_lut_rdata) : r_s2_rgb;

  color_lut_ram #(
    .DEPTH  (LUT_DEPTH),
    .ADDR_W (IDX_W),
    .DATA_W (24)
  ) u_lut (
    .clk   (clk),
    .we    (lut_we),
    .waddr (lut_addr),
    .wdata (lut_wdata),
    .re    (w_advance),
    .raddr (r_s1_idx),
    .rdata (w_lut_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_mode  <= PAL_JET;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_rgb   <= '0;
      r_s2_mode  <= PAL_JET;
      r_s2_sof   <= 1'b0;
      r_s2_eol   <= 1'b0;
      out_valid  <= 1'b0;
      r_rgb      <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s1_idx   <= w_idx;
      r_s1_mode  <= palette_e'(cfg_mode);
      r_s1_sof   <= in_sof && in_valid;
      r_s1_eol   <= in_eol && in_valid;

      r_s2_valid <= r_s1_valid;
      r_s2_rgb   <= w_pal;
      r_s2_mode  <= r_s1_mode;
      r_s2_sof   <= r_s1_sof;
      r_s2_eol   <= r_s1_eol;

      out_valid  <= r_s2_valid;
      r_rgb      <= w_s2_rgb;
      out_sof    <= r_s2_sof;
      out_eol    <= r_s2_eol;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_color_map_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_color_map_pipe : vector table, corner sequences and random scoreboard
// Rev 1.0
// ==========================================================================
module tb_color_map_pipe;

  localparam int IN_W = 12;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [IN_W-1:0] in_data;
  logic            in_sof;
  logic            in_eol;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      cfg_mode;
  logic [IN_W-1:0] cfg_lo;
  logic [15:0]     cfg_gain;
  logic            lut_we;
  logic [7:0]      lut_addr;
  logic [23:0]     lut_wdata;
  logic [23:0]     rgb;
  logic            out_sof;
  logic            out_eol;
  logic            out_valid;
  logic            out_ready;

  always #5 clk = ~clk;

  color_map_pipe #(.IN_W(IN_W), .GAIN_FRAC(8), .LUT_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sof(in_sof), .in_eol(in_eol),
    .in_valid(in_valid), .in_ready(in_ready), .cfg_mode(cfg_mode), .cfg_lo(cfg_lo),
    .cfg_gain(cfg_gain), .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .rgb(rgb), .out_sof(out_sof), .out_eol(out_eol), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int checks    = 0;
  int failures  = 0;
  int transfers = 0;
  logic [25:0] exp_q[$];
  logic [23:0] lut_m [256];

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] lo;
    logic [15:0] gain;
    logic [11:0] data;
    logic [23:0] exp_rgb;
  } vec_t;
  vec_t vecs [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int model_idx(input int d, input int lo, input int g);
    longint p;
    p = (d >= lo) ? longint'(d - lo) * longint'(g) : 0;
    p = p / 256;
    return (p > 255) ? 255 : int'(p);
  endfunction

  function automatic logic [23:0] model_rgb(input int mode, input int i, input logic [23:0] lv);
    int r, g, b;
    r = 0; g = 0; b = 0;
    if (mode == 3) return lv;
    if (mode == 1) begin
      r = i; g = i; b = i;
    end else if (mode == 0) begin
      if (i < 64)       begin r = 0;             g = 4 * i;               b = 255; end
      else if (i < 128) begin r = 0;             g = 255;                 b = 255 - 4 * (i - 64); end
      else if (i < 192) begin r = 4 * (i - 128); g = 255;                 b = 0; end
      else              begin r = 255;           g = 255 - 4 * (i - 192); b = 0; end
    end else begin
      r = (i < 85) ? 3 * i : 255;
      g = (i < 85) ? 0 : (i < 170) ? 3 * (i - 85) : 255;
      b = (i < 170) ? 0 : 3 * (i - 170);
    end
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  always @(posedge clk) begin
    if (lut_we) lut_m[lut_addr] <= lut_wdata;
  end

  // Scoreboard: a write landing on the acceptance edge is visible to that sample.
  int          m_idx;
  logic [23:0] m_lv;
  logic [25:0] m_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        m_idx = model_idx(int'(in_data), int'(cfg_lo), int'(cfg_gain));
        m_lv  = (lut_we && int'(lut_addr) == m_idx) ? lut_wdata : lut_m[m_idx];
        exp_q.push_back({model_rgb(int'(cfg_mode), m_idx, m_lv), in_sof, in_eol});
      end
      if (out_valid && out_ready) begin
        transfers++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra: unexpected output rgb=%h", rgb);
        end else begin
          m_e = exp_q.pop_front();
          check("sb_rgb", {8'd0, rgb}, {8'd0, m_e[25:2]});
          check("sb_sof", {31'd0, out_sof}, {31'd0, m_e[1]});
          check("sb_eol", {31'd0, out_eol}, {31'd0, m_e[0]});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_one(input logic [1:0] m, input logic [11:0] lo, input logic [15:0] g,
                           input logic [11:0] d, output logic [23:0] got, output int lat);
    @(posedge clk); #1;
    cfg_mode = m; cfg_lo = lo; cfg_gain = g; in_data = d;
    in_sof = 1'b0; in_eol = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("one_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    got = '0;
    for (int n = 1; n <= 10; n++) begin
      if (out_valid) begin
        lat = n;
        got = rgb;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  logic [23:0] got;
  int          lat;
  logic [23:0] rf [2];
  int          rf_n;
  int          t0;
  logic        pre_valid;

  initial begin
    vecs[0]  = '{2'd0, 12'h000, 16'h0010, 12'h3F0, 24'h00FCFF};
    vecs[1]  = '{2'd1, 12'h100, 16'h0100, 12'h050, 24'h000000};
    vecs[2]  = '{2'd1, 12'h000, 16'h0100, 12'hFFF, 24'hFFFFFF};
    vecs[3]  = '{2'd2, 12'h000, 16'h0100, 12'd84,  24'hFC0000};
    vecs[4]  = '{2'd2, 12'h000, 16'h0100, 12'd85,  24'hFF0000};
    vecs[5]  = '{2'd2, 12'h000, 16'h0100, 12'd170, 24'hFFFF00};
    vecs[6]  = '{2'd2, 12'h000, 16'h0100, 12'd255, 24'hFFFFFF};
    vecs[7]  = '{2'd2, 12'h000, 16'h0100, 12'd100, 24'hFF2D00};
    vecs[8]  = '{2'd0, 12'h000, 16'h0100, 12'd0,   24'h0000FF};
    vecs[9]  = '{2'd0, 12'h000, 16'h0100, 12'd64,  24'h00FFFF};
    vecs[10] = '{2'd0, 12'h000, 16'h0100, 12'd100, 24'h00FF6F};
    vecs[11] = '{2'd0, 12'h000, 16'h0100, 12'd150, 24'h58FF00};
    vecs[12] = '{2'd0, 12'h000, 16'h0100, 12'd200, 24'hFFDF00};
    vecs[13] = '{2'd1, 12'h200, 16'h0080, 12'h300, 24'h808080};

    rst_n = 1'b0; in_data = '0; in_sof = 1'b0; in_eol = 1'b0; in_valid = 1'b0;
    cfg_mode = 2'd0; cfg_lo = '0; cfg_gain = 16'h0100;
    lut_we = 1'b0; lut_addr = '0; lut_wdata = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rgb", {8'd0, rgb}, 32'd0);
    check("rst_sof_eol", {30'd0, out_sof, out_eol}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Preload the whole LUT with random colours.
    for (int a = 0; a < 256; a++) begin
      @(posedge clk); #1;
      lut_we = 1'b1; lut_addr = 8'(a); lut_wdata = 24'($urandom);
    end
    @(posedge clk); #1;
    lut_we = 1'b0;

    for (int k = 0; k < 14; k++) begin
      apply_one(vecs[k].mode, vecs[k].lo, vecs[k].gain, vecs[k].data, got, lat);
      check($sformatf("vec%0d_rgb", k), {8'd0, got}, {8'd0, vecs[k].exp_rgb});
      check($sformatf("vec%0d_latency", k), lat, 32'd3);
    end

    // LUT read-first: second write to lut[7] collides with the S1 read.
    @(posedge clk); #1;
    lut_we = 1'b1; lut_addr = 8'd7; lut_wdata = 24'h123456;
    @(posedge clk); #1;
    lut_we = 1'b0;
    cfg_mode = 2'd3; cfg_lo = '0; cfg_gain = 16'h0100; in_data = 12'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    lut_we = 1'b1; lut_addr = 8'd7; lut_wdata = 24'hABCDEF;
    @(posedge clk); #1;
    lut_we = 1'b0; in_valid = 1'b0;
    rf_n = 0;
    for (int n = 0; n < 12 && rf_n < 2; n++) begin
      @(negedge clk);
      if (out_valid) begin
        rf[rf_n] = rgb;
        rf_n++;
      end
    end
    check("rf_count", rf_n, 32'd2);
    check("rf_old", {8'd0, rf[0]}, 32'h00123456);
    check("rf_new", {8'd0, rf[1]}, 32'h00ABCDEF);
    repeat (3) @(posedge clk); #1;

    // Backpressure: 10 GRAY samples, out_ready low for 5 cycles mid-stream.
    t0 = transfers;
    cfg_mode = 2'd1; cfg_lo = '0; cfg_gain = 16'h0100;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          logic acc;
          int   guard;
          in_valid = 1'b1; in_data = 12'(k * 20 + 3);
          in_sof = (k == 0); in_eol = (k == 4 || k == 9);
          guard = 0;
          do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
          end while (!acc && guard < 50);
          if (!acc) check("bp_feed_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
      end
      begin
        logic [23:0] held;
        logic [1:0]  held_sb;
        repeat (4) @(posedge clk); #1;
        out_ready = 1'b0;
        held = '0; held_sb = '0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          if (s == 0) begin
            held = rgb; held_sb = {out_sof, out_eol};
            check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
          end
          check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
          check("bp_rgb_stable", {8'd0, rgb}, {8'd0, held});
          check("bp_sb_stable", {30'd0, out_sof, out_eol}, {30'd0, held_sb});
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk); #1;
    check("bp_count", transfers - t0, 32'd10);
    check("bp_drain", exp_q.size(), 32'd0);

    // Random traffic against the scoreboard, no LUT writes.
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 12'($urandom);
      in_sof    = ($urandom_range(0, 7) == 0);
      in_eol    = ($urandom_range(0, 7) == 0);
      cfg_mode  = 2'($urandom);
      cfg_lo    = 12'($urandom_range(0, 1023));
      cfg_gain  = 16'($urandom_range(0, 16'h0400));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; in_sof = 1'b0; in_eol = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("rand_drain", exp_q.size(), 32'd0);

    // Asynchronous reset between edges while the pipe is full.
    cfg_mode = 2'd1; cfg_lo = '0; cfg_gain = 16'h0100;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 12'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    pre_valid = out_valid;
    check("ar_pre_valid", {31'd0, pre_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_rgb", {8'd0, rgb}, 32'd0);
    check("ar_sb", {30'd0, out_sof, out_eol}, 32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("ar_post_valid", {31'd0, out_valid}, 32'd0);
    apply_one(2'd3, 12'h000, 16'h0100, 12'd7, got, lat);
    check("ar_lut_kept", {8'd0, got}, 32'h00ABCDEF);
    check("ar_latency", lat, 32'd3);
    repeat (3) @(posedge clk); #1;
    check("final_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/color_map_pipe.md
Name: color_map_pipe

Overview:
- Parametrised successor to the fixed jet colour mapper in the spectrogram display path.
- Takes IN_W-bit magnitude samples from the log/scaling stage and applies a runtime contrast window (offset + gain).
- Selects one of four palettes per sample (JET, GRAY, HOT, user LUT) and emits 24-bit RGB to the pixel writer.
- Uses a 3-stage valid/ready pipeline with backpressure and frame sideband.

Parameters:
- IN_W, 12, input sample width; legal range 8..16.
- GAIN_FRAC, 8, fractional bits of gain (unsigned fixed point).
- LUT_DEPTH, 256, user LUT entries; fixed to 256 because the index is 8 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  IN_W  input magnitude sample
- in_sof  in  1  first sample of frame (sideband)
- in_eol  in  1  last sample of line (sideband)
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept input this cycle
- cfg_mode  in  2  palette select: 0 JET, 1 GRAY, 2 HOT, 3 LUT
- cfg_lo  in  IN_W  window floor
- cfg_gain  in  16  window gain, unsigned, GAIN_FRAC fractional bits
- lut_we  in  1  LUT write enable
- lut_addr  in  8  LUT write address
- lut_wdata  in  24  LUT write data {r,g,b}
- rgb  out  24  {r,g,b}
- out_sof  out  1  sideband aligned with rgb
- out_eol  out  1  sideband aligned with rgb
- out_valid  out  1  rgb valid
- out_ready  in  1  downstream accepts

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all stage valids 0, rgb 0, out_sof/out_eol 0, out_valid 0. LUT contents are not reset.
- Advance rule: advance = !out_valid | out_ready. All three stages shift together when advance is 1; otherwise every stage holds.
- Input ready: in_ready = advance (combinational).
- Input acceptance: a sample is accepted when in_valid & in_ready.
- Output transfer: a transfer occurs when out_valid & out_ready. rgb and sideband hold stable while out_valid & !out_ready.
- Latency: 3 cycles from acceptance to out_valid when there is no stall. Throughput is 1 sample/clk.
- Configuration sampling: cfg_mode, cfg_lo and cfg_gain are sampled at acceptance and carried with the sample. A mid-stream mode change affects only samples accepted after the change.
- S1 (window):
  - off = in_data >= cfg_lo ? in_data - cfg_lo : 0.
  - prod = off * cfg_gain, full width IN_W+16.
  - idx = (prod >> GAIN_FRAC) saturated to 255.
- S2 (palette), 8-bit arithmetic, i = idx:
  - JET:
    - i<64: r=0, g=i*4, b=255.
    - i<128: r=0, g=255, b=255-(i-64)*4.
    - i<192: r=(i-128)*4, g=255, b=0.
    - else: r=255, g=255-(i-192)*4, b=0.
  - GRAY: r=g=b=i.
  - HOT:
    - r = i<85 ? 3i : 255.
    - g = i<85 ? 0 : i<170 ? 3(i-85) : 255.
    - b = i<170 ? 0 : 3(i-170).
  - LUT: synchronous read of lut[i], issued in S1 and registered into S2.
- S3: output register.
- LUT port:
  - Writes are accepted every cycle regardless of stall.
  - Same-cycle write and read to the same address is read-first (old data).
  - The LUT read enable is gated by advance so a stalled S2 keeps its data.
- Reset mid-operation: all in-flight samples are discarded. out_valid drops asynchronously. LUT is retained.

Decomposition:
- Package color_map_pkg:
  - typedef palette_e {PAL_JET, PAL_GRAY, PAL_HOT, PAL_LUT}.
  - typedef rgb_t, a packed struct {r,g,b} of 8 bits each.
  - constant IDX_W=8.
  - function jet(), function hot().
- One sub-module, color_lut_ram: 256x24, single write port, single registered read port with read enable, inferring BRAM.

Test Plan:
- JET sweep:
  - Stimulus: mode=0, lo=0, gain=0x0010 (1/16 with GAIN_FRAC=8, IN_W=12), in_data=0x3F0.
  - Response: idx=63, rgb=0x00FCFF, out_valid exactly 3 cycles after acceptance.
- Window saturation, with gain=0x0100:
  - in_data=0x050 with lo=0x100 -> idx=0 -> GRAY rgb=0x000000.
  - in_data=0xFFF with lo=0 -> idx=255 -> GRAY rgb=0xFFFFFF.
- HOT boundaries:
  - idx 84 -> 0xFC0000.
  - idx 85 -> 0xFF0000.
  - idx 170 -> 0xFFFF00.
  - idx 255 -> 0xFFFFFF.
- LUT read-first:
  - Write lut[7]=0x123456, then in a later cycle write lut[7]=0xABCDEF in the same cycle that S1 reads idx 7.
  - First sample -> 0x123456; the next sample at idx 7 -> 0xABCDEF.
- Backpressure:
  - Stream 10 samples while holding out_ready low for 5 cycles mid-stream.
  - Response: no loss or duplication, in_ready=0 while stalled, sof/eol stay aligned with their samples, rgb stable during the stall.
- Async reset:
  - Assert rst_n=0 mid-stream between clock edges.
  - Response: out_valid=0 and rgb=0 immediately.
  - After release, the first accepted sample appears 3 cycles later and LUT contents are unchanged.
